// File: rtl/lru_backend_arbiter.sv
// rtl/lru_backend_arbiter.sv - round-robin sharing of one backend read port between NUM_WAYS cache ways
//
// Purpose: each way posts a line tag on its request stream. One winner at a time is
// forwarded to the memory address stream, and the returned CACHE_SIZE/DATA_PORT_SIZE
// beats are passed straight through to that winner only.
//
// Optional feature macro: LRU_ARB_TIMEOUT_EN (adds watchdog and timeout_err output).
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_tvalid/req_tready/req_tdata   per-way tag request streams (tags packed per way)
//   rsp_tvalid/rsp_tready/rsp_tdata   per-way beat streams, tdata broadcast
//   mem_addr_tvalid/tready/tdata      memory request stream
//   mem_data_tvalid/tready/tdata      memory beat stream
//   grant_id                      current/last owner
//   busy                          fill in progress
//   timeout_err                   sticky watchdog flag (LRU_ARB_TIMEOUT_EN only)
module lru_backend_arbiter #(
    parameter int NUM_WAYS       = 4,
    parameter int TAGS_WIDTH     = 48,
    parameter int CACHE_SIZE     = 512,
    parameter int DATA_PORT_SIZE = 256,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_WAYS-1:0]            req_tvalid,
    output logic [NUM_WAYS-1:0]            req_tready,
    input  logic [NUM_WAYS*TAGS_WIDTH-1:0] req_tdata,
    output logic [NUM_WAYS-1:0]            rsp_tvalid,
    input  logic [NUM_WAYS-1:0]            rsp_tready,
    output logic [DATA_PORT_SIZE-1:0]      rsp_tdata,
    output logic                           mem_addr_tvalid,
    input  logic                           mem_addr_tready,
    output logic [TAGS_WIDTH-1:0]          mem_addr_tdata,
    input  logic                           mem_data_tvalid,
    output logic                           mem_data_tready,
    input  logic [DATA_PORT_SIZE-1:0]      mem_data_tdata,
    output logic [$clog2(NUM_WAYS)-1:0]    grant_id,
    output logic                           busy
`ifdef LRU_ARB_TIMEOUT_EN
    ,
    output logic                           timeout_err
`endif
);

    localparam int BEATS = CACHE_SIZE / DATA_PORT_SIZE;
    localparam int BW    = $clog2(BEATS) + 1;
    localparam int GW    = $clog2(NUM_WAYS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t                r_state;
    logic [GW-1:0]         r_rr_ptr;
    logic [GW-1:0]         r_grant;
    logic [BW-1:0]         r_beat_cnt;
    logic                  r_addr_valid;
    logic [TAGS_WIDTH-1:0] r_addr_tdata;

    logic                  w_found;
    logic [GW-1:0]         w_winner;
    int                    w_idx;
    logic [GW-1:0]         w_next_ptr;
    logic                  w_beat_hs;
    logic                  w_last_beat;

    // Circular search starting at r_rr_ptr; the first asserted request wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = 0;
        for (int k = 0; k < NUM_WAYS; k++) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= NUM_WAYS) begin
                w_idx = w_idx - NUM_WAYS;
            end
            if (!w_found && req_tvalid[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx[GW-1:0];
            end
        end
    end

    // The just-served way drops to lowest priority for the next search.
    assign w_next_ptr = (r_grant == GW'(NUM_WAYS - 1)) ? '0 : r_grant + GW'(1);

    assign req_tready      = (r_state == S_IDLE && w_found) ? (NUM_WAYS'(1) << w_winner) : '0;
    assign mem_data_tready = (r_state == S_DATA) && rsp_tready[r_grant];
    assign rsp_tvalid      = (r_state == S_DATA && mem_data_tvalid) ? (NUM_WAYS'(1) << r_grant) : '0;
    assign rsp_tdata       = mem_data_tdata;
    assign w_beat_hs       = mem_data_tvalid && mem_data_tready;
    assign w_last_beat     = (r_beat_cnt == BW'(BEATS - 1));

    assign mem_addr_tvalid = r_addr_valid;
    assign mem_addr_tdata  = r_addr_tdata;
    assign grant_id        = r_grant;
    assign busy            = (r_state != S_IDLE);

`ifdef LRU_ARB_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] r_wdog;
    logic          r_timeout_err;
    assign timeout_err = r_timeout_err;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_rr_ptr     <= '0;
            r_grant      <= '0;
            r_beat_cnt   <= '0;
            r_addr_valid <= 1'b0;
            r_addr_tdata <= '0;
`ifdef LRU_ARB_TIMEOUT_EN
            r_wdog        <= '0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant      <= w_winner;
                        r_addr_tdata <= req_tdata[int'(w_winner)*TAGS_WIDTH +: TAGS_WIDTH];
                        r_addr_valid <= 1'b1;
                        r_state      <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (r_addr_valid && mem_addr_tready) begin
                        r_addr_valid <= 1'b0;
                        r_beat_cnt   <= '0;
                        r_state      <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_beat_hs) begin
                        r_beat_cnt <= r_beat_cnt + BW'(1);
                        if (w_last_beat) begin
                            r_rr_ptr <= w_next_ptr;
                            r_state  <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase

`ifdef LRU_ARB_TIMEOUT_EN
            // Watchdog: restarts on entering ADDR and on each beat; on expiry it
            // abandons the fill and overrides whatever the case above decided.
            if (r_state == S_IDLE) begin
                r_wdog <= '0;
            end else if (w_beat_hs) begin
                r_wdog <= '0;
            end else if (r_wdog == WW'(TIMEOUT_CYCLES - 1)) begin
                r_wdog        <= '0;
                r_timeout_err <= 1'b1;
                r_addr_valid  <= 1'b0;
                r_rr_ptr      <= w_next_ptr;
                r_state       <= S_IDLE;
            end else begin
                r_wdog <= r_wdog + WW'(1);
            end
`endif
        end
    end

endmodule

// File: doc/lru_backend_arbiter.md
Name: lru_backend_arbiter

Overview:
- Shares one backend memory read port between NUM_WAYS LRU cache-way instances.
- Each way issues a tag (line address) request on its backend address stream, then receives CACHE_SIZE/DATA_PORT_SIZE data beats.
- Arbitration is round-robin with one outstanding line fill at a time; response beats return only to the granted way.
- Sits between the cache ways and the memory/DMA read engine in box_250mhz.

Parameters:
- NUM_WAYS, 4, number of requesting ways (2..8).
- TAGS_WIDTH, 48, request tag/address width.
- CACHE_SIZE, 512, cache line width in bits.
- DATA_PORT_SIZE, 256, data beat width; CACHE_SIZE is an integer multiple of it.
- TIMEOUT_CYCLES, 1024, watchdog limit (optional feature only).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_tvalid  in  NUM_WAYS  per-way address request valid.
- req_tready  out  NUM_WAYS  per-way address accept.
- req_tdata  in  NUM_WAYS*TAGS_WIDTH  per-way tags; way i occupies bits [i*TAGS_WIDTH +: TAGS_WIDTH].
- rsp_tvalid  out  NUM_WAYS  per-way data beat valid.
- rsp_tready  in  NUM_WAYS  per-way data beat ready.
- rsp_tdata  out  DATA_PORT_SIZE  data beat, broadcast to all ways; qualified by rsp_tvalid.
- mem_addr_tvalid  out  1  memory request valid.
- mem_addr_tready  in  1  memory request accept.
- mem_addr_tdata  out  TAGS_WIDTH  memory request tag.
- mem_data_tvalid  in  1  memory beat valid.
- mem_data_tready  out  1  memory beat ready.
- mem_data_tdata  in  DATA_PORT_SIZE  memory beat.
- grant_id  out  clog2(NUM_WAYS)  current/last owner.
- busy  out  1  fill in progress (state != IDLE).

Behaviour:
- BEATS = CACHE_SIZE/DATA_PORT_SIZE. The beat counter is clog2(BEATS)+1 bits wide.
- Reset: state IDLE; rr_ptr=0; grant_id=0; beat_cnt=0. All outputs are 0: req_tready, rsp_tvalid, mem_addr_tvalid, mem_addr_tdata, mem_data_tready, busy.
- **IDLE:**
  - Pick the first asserted req_tvalid at or after rr_ptr, circularly.
  - If one is found: register grant_id = winner and capture its tag into mem_addr_tdata. Pulse req_tready[winner] for that one cycle, which is the accept cycle for the way. Assert mem_addr_tvalid and go to ADDR next cycle.
  - Otherwise stay in IDLE.
  - Decision is made in the cycle valid is seen; req_tready is combinational from that decision. Latency from req_tvalid to mem_addr_tvalid is 1 cycle.
- **ADDR:**
  - Hold mem_addr_tvalid and mem_addr_tdata stable until mem_addr_tready.
  - On the handshake: deassert mem_addr_tvalid, beat_cnt=0, go to DATA.
- **DATA:**
  - mem_data_tready = rsp_tready[grant_id]; rsp_tvalid[grant_id] = mem_data_tvalid. All other rsp_tvalid bits are 0. rsp_tdata = mem_data_tdata (pass-through, zero latency).
  - Each beat handshake increments beat_cnt.
  - On the handshake with beat_cnt==BEATS-1: rr_ptr = grant_id+1 (wrapping at NUM_WAYS), go to IDLE.
- Stray memory data:
  - mem_data_tready is 0 outside DATA.
  - A mem_data_tvalid outside DATA is never forwarded.
- Round-robin fairness: a way that was just served has lowest priority next arbitration. With all ways requesting continuously, grants cycle 0,1,2,...,NUM_WAYS-1,0.
- A way dropping req_tvalid before being granted is legal; it is simply not selected.
- Simultaneous events:
  - New requests during ADDR/DATA are held off (req_tready=0).
  - Final-beat cycle and a new request: the request is arbitrated the next cycle, so there is 1 dead cycle between fills.
- Reset mid-fill returns to IDLE immediately. Any remaining memory beats are dropped (mem_data_tready=0). The memory engine is reset by the same rst.
- busy = (state != IDLE).

Optional Feature:
- Macro: LRU_ARB_TIMEOUT_EN.
- Enabled:
  - Adds output `timeout_err` (1 bit, reset 0, sticky until rst).
  - A watchdog counter is cleared on entering ADDR and on every beat handshake, and increments otherwise in ADDR/DATA.
  - On reaching TIMEOUT_CYCLES: set timeout_err, deassert mem_addr_tvalid, return to IDLE, advance rr_ptr past grant_id.
  - The stalled way receives no further beats.
- Disabled: no counter, no port; the arbiter waits indefinitely.

Test Plan:
- Single request: way 2 requests tag 0x1234, mem_addr_tready=1, mem returns 2 beats (0xA, 0xB) back-to-back.
  - req_tready[2] pulses 1 cycle; mem_addr_tdata=0x1234 one cycle later.
  - rsp_tvalid[2] is high for exactly 2 beats carrying 0xA, 0xB; busy falls the cycle after the last beat.
- All four ways request continuously, tags 0x10..0x13. Grant order is 0,1,2,3,0, and each fill gets exactly 2 beats to its owner only.
- mem_addr_tready held low 5 cycles. mem_addr_tvalid/tdata stay stable for all 5 cycles; no req_tready pulses occur meanwhile.
- Backpressure: rsp_tready[1]=0 for 3 cycles mid-burst. mem_data_tready=0 for those cycles; no beat is lost or duplicated; beat count stays 2.
- Reset asserted after first beat of a fill. Next cycle: busy=0, all rsp_tvalid=0, mem_data_tready=0; a new request from way 3 is then served normally.
- With LRU_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: no mem_data_tvalid after the address handshake.
  - timeout_err=1 after 16 cycles and state returns to IDLE.
  - Next pending way is granted.
